// File: rtl/read_index_allocator.sv
// read_index_allocator: tags host reads with a free read-return slot and registers requests toward the FIFO
module read_index_allocator #(
    parameter int READ_ENTRIES = 16,
    parameter int IDX_W        = $clog2(READ_ENTRIES),
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_grant,
    input  logic              in_type,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_grant,
    output logic              out_type,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_index,
    input  logic              free_valid,
    input  logic [IDX_W-1:0]  free_index,
    output logic [IDX_W:0]    outstanding,
    output logic              err_double_free
);
    typedef enum logic {EMPTY, HOLD} state_t;
    state_t                  state;
    logic [READ_ENTRIES-1:0] busy;
    logic [IDX_W-1:0]        alloc_idx;
    logic                    alloc, rel;
    always_comb begin
        alloc_idx = '0;
        for (int i = READ_ENTRIES - 1; i >= 0; i--) alloc_idx = busy[i] ? alloc_idx : IDX_W'(i);
    end
    assign in_grant  = in_valid && (in_type || !(&busy)) && (state == EMPTY || out_grant);
    assign alloc     = in_grant && !in_type;
    assign rel       = free_valid && busy[free_index];
    assign out_valid = state == HOLD;
    // allocation sees the pre-release bitmap, so a freed slot is never bypassed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= EMPTY;
            busy            <= '0;
            out_type        <= 1'b0;
            out_addr        <= '0;
            out_data        <= '0;
            out_index       <= '0;
            outstanding     <= '0;
            err_double_free <= 1'b0;
        end else begin
            state <= in_grant ? HOLD : (out_grant ? EMPTY : state);
            if (in_grant) begin
                out_type  <= in_type;
                out_addr  <= in_addr;
                out_data  <= in_type ? in_data : '0;
                out_index <= in_type ? '0 : alloc_idx;
            end
            busy            <= (busy & ~(READ_ENTRIES'(rel) << free_index)) | (READ_ENTRIES'(alloc) << alloc_idx);
            outstanding     <= outstanding + (IDX_W+1)'(alloc) - (IDX_W+1)'(rel);
            err_double_free <= free_valid && !rel;
        end
    end
endmodule

// File: tb/tb_read_index_allocator.sv
// tb_read_index_allocator: table-driven, directed and randomized checks of read_index_allocator with 4 slots
module tb_read_index_allocator;
    localparam int N = 4;
    logic        clk = 0, rst_n = 0;
    logic        in_valid = 0, in_type = 0, out_grant = 0, free_valid = 0;
    logic [31:0] in_addr = 0;
    logic [15:0] in_data = 0;
    logic [1:0]  free_index = 0;
    logic        in_grant, out_valid, out_type, err_double_free;
    logic [31:0] out_addr;
    logic [15:0] out_data;
    logic [1:0]  out_index;
    logic [2:0]  outstanding;
    int          total = 0, passed = 0;

    read_index_allocator #(.READ_ENTRIES(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_grant(in_grant), .in_type(in_type),
        .in_addr(in_addr), .in_data(in_data), .out_valid(out_valid), .out_grant(out_grant),
        .out_type(out_type), .out_addr(out_addr), .out_data(out_data), .out_index(out_index),
        .free_valid(free_valid), .free_index(free_index), .outstanding(outstanding),
        .err_double_free(err_double_free)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v, t; logic [31:0] a; logic [15:0] d; logic og, fv; logic [1:0] fi;
        logic eg, ev; logic [1:0] ei; logic [15:0] ed; logic [2:0] eo; logic ee;
    } vec_t;
    vec_t tbl[13];

    function automatic vec_t mk(logic v, logic t, logic [31:0] a, logic [15:0] d, logic og, logic fv,
                                logic [1:0] fi, logic eg, logic ev, logic [1:0] ei, logic [15:0] ed,
                                logic [2:0] eo, logic ee);
        vec_t r;
        r.v = v; r.t = t; r.a = a; r.d = d; r.og = og; r.fv = fv; r.fi = fi;
        r.eg = eg; r.ev = ev; r.ei = ei; r.ed = ed; r.eo = eo; r.ee = ee;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(logic v, logic t, logic [31:0] a, logic [15:0] d, logic og, logic fv, logic [1:0] fi);
        in_valid = v; in_type = t; in_addr = a; in_data = d; out_grant = og; free_valid = fv; free_index = fi;
    endtask

    // reference model: busy flags per slot plus one held request
    bit          m_busy[N];
    bit          m_hv, m_ht;
    logic [31:0] m_ha;
    logic [15:0] m_hd;
    int          m_hi;
    bit          m_err;

    function automatic int m_count();
        int c = 0;
        foreach (m_busy[k]) c += m_busy[k];
        return c;
    endfunction

    initial begin
        tbl[0]  = mk(1, 0, 32'h100, 16'h1111, 1, 0, 0, 1, 1, 0, 0, 1, 0);
        tbl[1]  = mk(1, 0, 32'h104, 16'h2222, 1, 0, 0, 1, 1, 1, 0, 2, 0);
        tbl[2]  = mk(1, 0, 32'h108, 16'h0, 1, 0, 0, 1, 1, 2, 0, 3, 0);
        tbl[3]  = mk(1, 0, 32'h10C, 16'h0, 1, 0, 0, 1, 1, 3, 0, 4, 0);
        tbl[4]  = mk(1, 0, 32'h110, 16'h0, 1, 0, 0, 0, 0, 0, 0, 4, 0);
        tbl[5]  = mk(1, 0, 32'h110, 16'h0, 1, 1, 2, 0, 0, 0, 0, 3, 0);
        tbl[6]  = mk(1, 0, 32'h110, 16'h0, 1, 0, 0, 1, 1, 2, 0, 4, 0);
        tbl[7]  = mk(1, 1, 32'h40, 16'hBEEF, 1, 0, 0, 1, 1, 0, 16'hBEEF, 4, 0);
        tbl[8]  = mk(1, 0, 32'h200, 16'h0, 1, 1, 1, 0, 0, 0, 0, 3, 0);
        tbl[9]  = mk(1, 0, 32'h200, 16'h0, 1, 0, 0, 1, 1, 1, 0, 4, 0);
        tbl[10] = mk(0, 0, 32'h0, 16'h0, 1, 1, 3, 0, 0, 0, 0, 3, 0);
        tbl[11] = mk(0, 0, 32'h0, 16'h0, 1, 1, 3, 0, 0, 0, 0, 3, 1);
        tbl[12] = mk(0, 0, 32'h0, 16'h0, 1, 0, 0, 0, 0, 0, 0, 3, 0);

        #12 chk("reset out_valid", 32'(out_valid), 0);
        chk("reset outstanding", 32'(outstanding), 0);
        chk("reset out_addr", out_addr, 0);
        chk("reset out_index", 32'(out_index), 0);
        chk("reset err", 32'(err_double_free), 0);
        @(negedge clk) rst_n = 1;

        foreach (tbl[r]) begin
            @(negedge clk);
            drive(tbl[r].v, tbl[r].t, tbl[r].a, tbl[r].d, tbl[r].og, tbl[r].fv, tbl[r].fi);
            #1 chk($sformatf("row%0d in_grant", r), 32'(in_grant), 32'(tbl[r].eg));
            @(posedge clk); #1;
            chk($sformatf("row%0d out_valid", r), 32'(out_valid), 32'(tbl[r].ev));
            if (tbl[r].ev) begin
                chk($sformatf("row%0d out_type", r), 32'(out_type), 32'(tbl[r].t));
                chk($sformatf("row%0d out_addr", r), out_addr, tbl[r].a);
                chk($sformatf("row%0d out_data", r), 32'(out_data), 32'(tbl[r].ed));
                chk($sformatf("row%0d out_index", r), 32'(out_index), 32'(tbl[r].ei));
            end
            chk($sformatf("row%0d outstanding", r), 32'(outstanding), 32'(tbl[r].eo));
            chk($sformatf("row%0d err", r), 32'(err_double_free), 32'(tbl[r].ee));
        end

        // stall in HOLD, then back-to-back reload without a bubble
        @(negedge clk) drive(1, 0, 32'h300, 16'h0, 0, 0, 0);
        #1 chk("hold read grant", 32'(in_grant), 1);
        @(posedge clk); #1 chk("hold read index", 32'(out_index), 3);
        chk("hold outstanding", 32'(outstanding), 4);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk) drive(1, 1, 32'h304, 16'h1234, 0, 0, 0);
            #1 chk("stall grant", 32'(in_grant), 0);
            @(posedge clk); #1;
            chk("stall valid", 32'(out_valid), 1);
            chk("stall addr", out_addr, 32'h300);
            chk("stall index", 32'(out_index), 3);
            chk("stall type", 32'(out_type), 0);
        end
        @(negedge clk) out_grant = 1;
        #1 chk("b2b grant", 32'(in_grant), 1);
        @(posedge clk); #1;
        chk("b2b valid", 32'(out_valid), 1);
        chk("b2b addr", out_addr, 32'h304);
        chk("b2b data", 32'(out_data), 32'h1234);
        chk("b2b type", 32'(out_type), 1);
        chk("b2b index", 32'(out_index), 0);

        // asynchronous reset while holding
        @(negedge clk) drive(0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 0;
        #1 chk("mid reset valid", 32'(out_valid), 0);
        chk("mid reset outstanding", 32'(outstanding), 0);
        @(negedge clk) rst_n = 1;

        // randomized run against the reference model
        foreach (m_busy[k]) m_busy[k] = 0;
        m_hv = 0; m_err = 0;
        for (int n = 0; n < 2000; n++) begin
            bit eg, ok;
            int fi, idx;
            @(negedge clk);
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, $urandom, 16'($urandom),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)));
            ok = in_type || (m_count() < N);
            eg = in_valid && ok && (!m_hv || out_grant);
            #1 chk("rand in_grant", 32'(in_grant), 32'(eg));
            fi = int'(free_index);
            m_err = free_valid && !m_busy[fi];
            if (eg) begin
                idx = 0;
                if (!in_type) begin
                    idx = -1;
                    foreach (m_busy[k]) if (!m_busy[k] && idx < 0) idx = k;
                end
                m_hv = 1; m_ht = in_type; m_ha = in_addr; m_hd = in_type ? in_data : 16'h0; m_hi = idx;
            end else if (out_grant) m_hv = 0;
            if (free_valid && m_busy[fi]) m_busy[fi] = 0;
            if (eg && !in_type) m_busy[m_hi] = 1;
            @(posedge clk); #1;
            chk("rand out_valid", 32'(out_valid), 32'(m_hv));
            if (m_hv) begin
                chk("rand out_type", 32'(out_type), 32'(m_ht));
                chk("rand out_addr", out_addr, m_ha);
                chk("rand out_data", 32'(out_data), 32'(m_hd));
                chk("rand out_index", 32'(out_index), 32'(m_hi));
            end
            chk("rand outstanding", 32'(outstanding), 32'(m_count()));
            chk("rand err", 32'(err_double_free), 32'(m_err));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
